// File: rtl/lfsr_tick_gen.sv
// Galois LFSR that advances once per synchronised rising edge of a divided clock,
// with load/fallback seeding, a one-cycle valid strobe and a full-period marker.
module lfsr_tick_gen #(
    parameter int unsigned      WIDTH = 8,
    parameter logic [WIDTH-1:0] TAPS  = WIDTH'('hB8),
    parameter logic [WIDTH-1:0] SEED  = WIDTH'('h01)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             tick_in,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] seed_in,
    output logic [WIDTH-1:0] rnd_out,
    output logic             valid,
    output logic             period_done,
    output logic             lockup
);

    // Counter value at which the step completing 2^WIDTH-1 steps occurs.
    localparam logic [WIDTH-1:0] CNT_LAST = {{(WIDTH-1){1'b1}}, 1'b0};

    logic             r_s1;
    logic             r_s2;
    logic             r_s3;
    logic [1:0]       r_fill;
    logic             r_armed;
    logic [WIDTH-1:0] r_state;
    logic [WIDTH-1:0] r_cnt;
    logic             r_valid;
    logic             r_pdone;
    logic             r_lockup;

    logic             w_edge;
    logic             w_step;
    logic             w_wrap;
    logic [WIDTH-1:0] w_next;

    always_comb begin
        w_edge = r_s2 & ~r_s3;
        w_step = w_edge & r_armed & en & ~load;
        w_wrap = w_step & (r_cnt == CNT_LAST);
        w_next = r_state[0] ? ((r_state >> 1) ^ TAPS) : (r_state >> 1);
    end

    // Arming only trusts s2 once it holds a real sample (r_fill), so the reset
    // zeros in the synchroniser cannot arm it ahead of a tick held high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1    <= 1'b0;
            r_s2    <= 1'b0;
            r_s3    <= 1'b0;
            r_fill  <= '0;
            r_armed <= 1'b0;
        end else begin
            r_s1    <= tick_in;
            r_s2    <= r_s1;
            r_s3    <= r_s2;
            r_fill  <= {r_fill[0], 1'b1};
            r_armed <= r_armed | (r_fill[1] & ~r_s2);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= SEED;
            r_cnt    <= '0;
            r_valid  <= 1'b0;
            r_pdone  <= 1'b0;
            r_lockup <= 1'b0;
        end else begin
            r_valid <= load | w_step;
            r_pdone <= w_wrap;
            if (load) begin
                r_cnt <= '0;
                if (|seed_in) begin
                    r_state  <= seed_in;
                    r_lockup <= 1'b0;
                end else begin
                    r_state  <= SEED;
                    r_lockup <= 1'b1;
                end
            end else if (w_step) begin
                r_state <= w_next;
                r_cnt   <= w_wrap ? '0 : r_cnt + 1'b1;
            end
        end
    end

    assign rnd_out     = r_state;
    assign valid       = r_valid;
    assign period_done = r_pdone;
    assign lockup      = r_lockup;

endmodule

// File: tb/tb_lfsr_tick_gen.sv
// Bench for lfsr_tick_gen: directed and randomised edges/loads against a
// behavioural model of the LFSR sequence, step count and lockup flag.
module tb_lfsr_tick_gen;

    localparam logic [7:0] SEED_M = 8'h01;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       tick_in;
    logic       en;
    logic       load;
    logic [7:0] seed_in;
    logic [7:0] rnd_out;
    logic       valid;
    logic       period_done;
    logic       lockup;

    lfsr_tick_gen #(
        .WIDTH (8),
        .TAPS  (8'hB8),
        .SEED  (8'h01)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .tick_in     (tick_in),
        .en          (en),
        .load        (load),
        .seed_in     (seed_in),
        .rnd_out     (rnd_out),
        .valid       (valid),
        .period_done (period_done),
        .lockup      (lockup)
    );

    always #5 clk = ~clk;

    int         vectors     = 0;
    int         miscompares = 0;
    logic [7:0] m_state;
    logic       m_lock;
    int         m_steps;
    int         pd_count;
    bit         seen [256];
    logic [7:0] five_tbl [5];

    function automatic logic [7:0] ref_next(input logic [7:0] s);
        int v;
        v = int'(s);
        if (v % 2 == 1) return 8'((v / 2) ^ 184);
        return 8'(v / 2);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        vectors++;
        assert (obs === exp_v) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic model_load(input logic [7:0] v);
        if (v != 8'h00) begin
            m_state = v;
            m_lock  = 1'b0;
        end else begin
            m_state = SEED_M;
            m_lock  = 1'b1;
        end
        m_steps = 0;
    endtask

    task automatic do_load(input logic [7:0] v);
        load    = 1'b1;
        seed_in = v;
        cyc();
        model_load(v);
        chk("load_rnd", rnd_out, m_state);
        chk("load_valid", valid, 1);
        chk("load_lockup", lockup, m_lock);
        chk("load_pdone", period_done, 0);
        load = 1'b0;
    endtask

    // One tick_in period: high for h cycles then low for l. The step (or a
    // coincident load) is expected exactly at the third clk edge.
    task automatic do_edge(input bit en_v, input bit ld, input logic [7:0] ld_v);
        int h;
        int l;
        bit exp_v;
        bit exp_pd;
        h  = $urandom_range(2, 4);
        l  = $urandom_range(2, 4);
        en = en_v;
        for (int i = 1; i <= h + l; i++) begin
            tick_in = (i <= h);
            if (ld && i == 3) begin
                load    = 1'b1;
                seed_in = ld_v;
            end
            cyc();
            exp_v  = 1'b0;
            exp_pd = 1'b0;
            if (i == 3) begin
                if (ld) begin
                    model_load(ld_v);
                    exp_v = 1'b1;
                end else if (en_v) begin
                    m_state = ref_next(m_state);
                    m_steps++;
                    exp_v = 1'b1;
                    if (m_steps == 255) begin
                        m_steps = 0;
                        exp_pd  = 1'b1;
                    end
                end
            end
            load = 1'b0;
            if (period_done === 1'b1) pd_count++;
            chk("edge_valid", valid, exp_v);
            chk("edge_pdone", period_done, exp_pd);
            chk("edge_rnd", rnd_out, m_state);
            chk("edge_lockup", lockup, m_lock);
        end
    endtask

    initial begin
        logic [7:0] rv;
        int         r;
        rst_n    = 1'b0;
        tick_in  = 1'b1;
        en       = 1'b1;
        load     = 1'b0;
        seed_in  = 8'h00;
        m_state  = SEED_M;
        m_lock   = 1'b0;
        m_steps  = 0;
        pd_count = 0;
        five_tbl = '{8'hB8, 8'h5C, 8'h2E, 8'h17, 8'hB3};

        // tick_in high through reset must not produce a step
        repeat (3) cyc();
        chk("rst_rnd", rnd_out, 8'h01);
        chk("rst_valid", valid, 0);
        chk("rst_pdone", period_done, 0);
        chk("rst_lockup", lockup, 0);
        rst_n = 1'b1;
        repeat (6) begin
            cyc();
            chk("held_valid", valid, 0);
            chk("held_rnd", rnd_out, 8'h01);
        end
        tick_in = 1'b0;
        repeat (4) cyc();

        for (int k = 0; k < 5; k++) begin
            do_edge(1'b1, 1'b0, 8'h00);
            chk("five_steps", rnd_out, five_tbl[k]);
        end

        // Full period from SEED
        do_load(8'h01);
        foreach (seen[j]) seen[j] = 1'b0;
        seen[1]  = 1'b1;
        pd_count = 0;
        for (int k = 1; k <= 255; k++) begin
            do_edge(1'b1, 1'b0, 8'h00);
            if (k < 255) begin
                chk("no_repeat", seen[rnd_out], 0);
                seen[rnd_out] = 1'b1;
            end
            if (k == 254) chk("pd_early", pd_count, 0);
        end
        chk("pd_once", pd_count, 1);
        chk("period_wrap", rnd_out, 8'h01);

        // Zero load falls back to SEED; back-to-back loads
        do_load(8'h00);
        chk("lock_rnd", rnd_out, 8'h01);
        chk("lock_set", lockup, 1);
        do_load(8'h5C);
        chk("lock_clr", lockup, 0);
        do_edge(1'b1, 1'b0, 8'h00);
        chk("after_lock_step", rnd_out, 8'h2E);

        // Edges while disabled are dropped, not queued
        repeat (3) do_edge(1'b0, 1'b0, 8'h00);
        chk("en_hold", rnd_out, 8'h2E);
        do_edge(1'b1, 1'b0, 8'h00);
        chk("en_single", rnd_out, 8'h17);

        do_edge(1'b1, 1'b1, 8'h33);
        chk("coinc_rnd", rnd_out, 8'h33);
        do_edge(1'b1, 1'b0, 8'h00);
        chk("coinc_next", rnd_out, 8'hA1);

        // Load on the period-completing step suppresses the step and period_done
        do_load(8'h01);
        repeat (254) do_edge(1'b1, 1'b0, 8'h00);
        pd_count = 0;
        do_edge(1'b1, 1'b1, 8'h77);
        chk("pd_suppressed", pd_count, 0);
        chk("pd_load_rnd", rnd_out, 8'h77);
        do_edge(1'b1, 1'b0, 8'h00);
        chk("pd_after_load", pd_count, 0);

        repeat (40) begin
            r = $urandom_range(0, 7);
            rv = 8'($urandom_range(0, 255));
            if ($urandom_range(0, 3) == 0) rv = 8'h00;
            if (r == 0) do_load(rv);
            else do_edge(1'($urandom_range(0, 1)), r == 1, rv);
        end

        // Asynchronous reset in the middle of a valid pulse
        do_load(8'h00);
        do_edge(1'b1, 1'b0, 8'h00);
        chk("pre_rst_rnd", rnd_out, 8'hB8);
        en      = 1'b1;
        tick_in = 1'b1;
        repeat (3) cyc();
        chk("pre_rst_valid", valid, 1);
        chk("pre_rst_lock", lockup, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_rnd", rnd_out, 8'h01);
        chk("mid_rst_valid", valid, 0);
        chk("mid_rst_pdone", period_done, 0);
        chk("mid_rst_lockup", lockup, 0);
        @(posedge clk);
        #1;
        rst_n   = 1'b1;
        tick_in = 1'b0;
        m_state = SEED_M;
        m_lock  = 1'b0;
        m_steps = 0;
        repeat (5) cyc();
        do_edge(1'b1, 1'b0, 8'h00);
        chk("post_rst_step", rnd_out, 8'hB8);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
